// File: rtl/slider_debounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : slider_debounce_ctrl
//  Purpose  : Avalon-MM slave that owns the board slide switches. The raw
//             switch bus is synchronised, debounced and published as a stable
//             value. Per-bit change events are latched into an edge-capture
//             register, and a maskable level interrupt is raised.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         system clock
//    reset       asynchronous, active-high reset
//    address     Avalon word address (0 stable, 1 irqmask, 2 change count,
//                3 edgecapture)
//    chipselect  Avalon select
//    write_n     Avalon write strobe, active low
//    writedata   Avalon write data
//    readdata    Avalon read data, registered (read latency 1)
//    in_port     raw switch pins, asynchronous to clk
//    irq         level interrupt, active high
//  Build option
//    SLIDER_CHANGE_COUNT_EN  when defined, adds a saturating 16-bit commit
//                            counter at address 2 (cleared by any write there)
// ============================================================================
module slider_debounce_ctrl #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_COUNTING = 1'b1
    } state_t;

    // Count value at which the candidate has been stable long enough.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // Synchroniser
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

    // ------------------------------------------------------------------
    // Debounce FSM
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_s2_prev;
    logic [WIDTH-1:0] r_stable;

    logic w_s2_changed;
    logic w_commit;

    assign w_s2_changed = (r_s2 != r_s2_prev);

    // Candidate has held for DEBOUNCE_CYCLES cycles without moving.
    assign w_commit = (r_state == S_COUNTING) && (r_s2 != r_stable) &&
                      !w_s2_changed && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_s2_prev <= '0;
            r_stable  <= '0;
        end else begin
            r_s2_prev <= r_s2;
            case (r_state)
                S_IDLE: begin
                    if (r_s2 != r_stable) begin
                        r_state <= S_COUNTING;
                        r_cnt   <= c_CNT_ONE;
                    end
                end
                S_COUNTING: begin
                    if (r_s2 == r_stable) begin
                        // Bounce settled back onto the old value.
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else if (w_s2_changed) begin
                        // New candidate: restart the stability window.
                        r_cnt <= c_CNT_ONE;
                    end else if (w_commit) begin
                        r_stable <= r_s2;
                        r_state  <= S_IDLE;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic             w_wr;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;

    assign w_wr    = chipselect && !write_n;
    assign w_event = w_commit ? (r_stable ^ r_s2) : '0;
    assign w_clear = (w_wr && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask <= '0;
            r_edgecap <= '0;
            irq       <= 1'b0;
        end else begin
            if (w_wr && (address == 2'd1)) begin
                r_irqmask <= writedata[WIDTH-1:0];
            end
            // Clear is applied first so a same-cycle event survives.
            r_edgecap <= (r_edgecap & ~w_clear) | w_event;
            irq       <= |(r_edgecap & r_irqmask);
        end
    end

    // ------------------------------------------------------------------
    // Optional commit counter
    // ------------------------------------------------------------------
    logic [15:0] w_cnt_rd;

`ifdef SLIDER_CHANGE_COUNT_EN
    logic [15:0] r_chg_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chg_cnt <= '0;
        end else if (w_wr && (address == 2'd2)) begin
            r_chg_cnt <= '0;
        end else if (w_commit && (r_chg_cnt != 16'hFFFF)) begin
            r_chg_cnt <= r_chg_cnt + 16'd1;
        end
    end

    assign w_cnt_rd = r_chg_cnt;
`else
    assign w_cnt_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] w_rd_mux;

    always_comb begin
        w_rd_mux = '0;
        case (address)
            2'd0:    w_rd_mux[WIDTH-1:0] = r_stable;
            2'd1:    w_rd_mux[WIDTH-1:0] = r_irqmask;
            2'd2:    w_rd_mux[15:0]      = w_cnt_rd;
            default: w_rd_mux[WIDTH-1:0] = r_edgecap;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (chipselect) begin
            readdata <= w_rd_mux;
        end
    end

    // Upper write-data bits carry no register content.
    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, writedata[31:WIDTH]};

endmodule
`default_nettype wire

// File: tb/tb_slider_debounce_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slider_debounce_ctrl
//  Purpose  : Directed self-checking bench for slider_debounce_ctrl with
//             DEBOUNCE_CYCLES=8. Inputs change on the falling edge, outputs
//             are sampled on the falling edge after each rising edge.
//             Honours SLIDER_CHANGE_COUNT_EN for the address-2 checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_slider_debounce_ctrl;

    localparam int WIDTH = 10;

    logic             clk;
    logic             reset;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int checks;
    int errors;
    logic [31:0] v;

    slider_debounce_ctrl #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (8),
        .CNT_W           (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        tick();
        write_n   = 1'b1;
        address   = 2'd0;
        writedata = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d       = readdata;
        address = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        in_port    = '0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;

        // Reset state
        wait_ticks(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset      = 1'b0;
        chipselect = 1'b1;
        rd(2'd1, v); chk("reset_irqmask", v, 32'h0);
        rd(2'd3, v); chk("reset_edgecap", v, 32'h0);

        // Bit 0 rises: s2 moves 2 edges later, commit 8 edges after that,
        // readdata (addr 0) shows it one edge after the commit.
        in_port = 10'h001;
        wait_ticks(10);
        chk("b0_before_commit", readdata, 32'h000);
        tick();
        chk("b0_stable", readdata, 32'h001);
        chk("b0_irq_masked", 32'(irq), 32'h0);
        rd(2'd3, v); chk("b0_edgecap", v, 32'h001);

        // Unmasking a pending capture raises irq one cycle later.
        wr(2'd1, 32'h3FF);
        chk("mask_irq_lag", 32'(irq), 32'h0);
        tick();
        chk("mask_irq_rise", 32'(irq), 32'h1);
        rd(2'd1, v); chk("irqmask_rd", v, 32'h3FF);
        chipselect = 1'b0;
        tick();
        chk("rd_hold_no_cs", readdata, 32'h3FF);
        chipselect = 1'b1;

        // Bit 5 rises.
        in_port = 10'h021;
        wait_ticks(10);
        chk("b5_before_commit", readdata, 32'h001);
        tick();
        chk("b5_stable", readdata, 32'h021);
        rd(2'd3, v); chk("b5_edgecap", v, 32'h021);
        wr(2'd3, 32'h020);
        chk("clr5_irq_stays", 32'(irq), 32'h1);
        rd(2'd3, v); chk("clr5_edgecap", v, 32'h001);
        chk("clr5_irq_still", 32'(irq), 32'h1);
        wr(2'd3, 32'h001);
        chk("clr0_irq_lag", 32'(irq), 32'h1);
        tick();
        chk("clr0_irq_drop", 32'(irq), 32'h0);

        // Bit 9 bounces every 3 cycles for 30 cycles, then settles high.
        for (int k = 0; k < 10; k++) begin
            in_port = (k % 2 == 0) ? 10'h221 : 10'h021;
            wait_ticks(3);
        end
        chk("bounce_no_commit", readdata, 32'h021);
        chk("bounce_no_irq", 32'(irq), 32'h0);
        in_port = 10'h221;
        wait_ticks(10);
        chk("b9_before_commit", readdata, 32'h021);
        chk("b9_irq_before", 32'(irq), 32'h0);
        tick();
        chk("b9_stable", readdata, 32'h221);
        chk("b9_irq_rise", 32'(irq), 32'h1);
        wr(2'd3, 32'h200);
        tick();
        chk("clr9_irq_drop", 32'(irq), 32'h0);

        // Bit 2 glitches high for 4 cycles.
        in_port = 10'h225;
        wait_ticks(4);
        in_port = 10'h221;
        wait_ticks(12);
        chk("glitch_stable", readdata, 32'h221);
        chk("glitch_irq", 32'(irq), 32'h0);
        rd(2'd3, v); chk("glitch_edgecap", v, 32'h000);

        // Write-1-clear on bit 3 in the same cycle as the bit 3 commit.
        in_port = 10'h229;
        wait_ticks(9);
        chk("b3_before_commit", readdata, 32'h221);
        address   = 2'd3;
        writedata = 32'h008;
        write_n   = 1'b0;
        tick();
        write_n   = 1'b1;
        address   = 2'd0;
        writedata = '0;
        rd(2'd3, v); chk("b3_event_wins", v, 32'h008);
        chk("b3_irq", 32'(irq), 32'h1);
        wr(2'd3, 32'h008);
        tick();
        chk("clr3_irq_drop", 32'(irq), 32'h0);

        // Bit 0 falls: falling edges are captured too.
        in_port = 10'h228;
        wait_ticks(11);
        chk("fall_stable", readdata, 32'h228);
        rd(2'd3, v); chk("fall_edgecap", v, 32'h001);
        chk("fall_irq", 32'(irq), 32'h1);

        // Reset while the debounce count is at 5.
        in_port = 10'h0F0;
        wait_ticks(7);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        reset = 1'b1;
        #1;
        chk("midreset_readdata", readdata, 32'h0);
        chk("midreset_irq", 32'(irq), 32'h0);
        wait_ticks(2);
        reset = 1'b0;
        wait_ticks(10);
        chk("pwrup_before_commit", readdata, 32'h000);
        tick();
        chk("pwrup_stable", readdata, 32'h0F0);
        rd(2'd3, v); chk("pwrup_edgecap", v, 32'h0F0);
        rd(2'd1, v); chk("pwrup_irqmask", v, 32'h0);
        chk("pwrup_irq", 32'(irq), 32'h0);

        // Address 0 is read-only.
        wr(2'd0, 32'h3FF);
        rd(2'd0, v); chk("addr0_ro", v, 32'h0F0);

`ifdef SLIDER_CHANGE_COUNT_EN
        rd(2'd2, v); chk("cnt_pwrup", v, 32'd1);
        wr(2'd2, 32'h0);
        rd(2'd2, v); chk("cnt_clear1", v, 32'd0);
        in_port = 10'h0F1; wait_ticks(12);
        in_port = 10'h0F3; wait_ticks(12);
        in_port = 10'h0F7; wait_ticks(12);
        rd(2'd2, v); chk("cnt_three", v, 32'd3);
        wr(2'd2, 32'h0);
        rd(2'd2, v); chk("cnt_clear2", v, 32'd0);
`else
        wr(2'd2, 32'hFFFF);
        rd(2'd2, v); chk("addr2_zero", v, 32'd0);
        in_port = 10'h0F1; wait_ticks(12);
        rd(2'd2, v); chk("addr2_zero_after_commit", v, 32'd0);
        rd(2'd0, v); chk("final_stable", v, 32'h0F1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
